// File: rtl/mrc_result_bcd_pkg.sv
// Shared MRC definitions: datapath width, BCD digit width and result-stage state encoding.
package mrc_defs;

  localparam int MRC_WORD_LENGTH = 16;
  localparam int BCD_DIGIT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } mrc_state_e;

endpackage

// File: rtl/mrc_result_bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_add3
  import mrc_defs::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = (din >= BCD_DIGIT_W'(5)) ? din + BCD_DIGIT_W'(3) : din;

endmodule

// File: rtl/mrc_result_bcd.sv
// Captures the signed MRC result, converts its magnitude to packed BCD one bit per clock,
// and holds digits plus sign for the display driver.
module mrc_result_bcd
  import mrc_defs::*;
#(
  parameter int WORD_LENGTH = MRC_WORD_LENGTH,
  parameter int NDIGITS     = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     result_valid,
  input  logic [2*WORD_LENGTH-1:0] result,
  output logic                     busy,
  output logic                     done,
  output logic                     neg_out,
  output logic [4*NDIGITS-1:0]     bcd_out
);

  localparam int RW = 2*WORD_LENGTH;
  localparam int BW = BCD_DIGIT_W*NDIGITS;
  localparam int CW = $clog2(RW+1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(RW-1);

  mrc_state_e     state_reg;
  logic [RW-1:0]  in_reg;
  logic [RW-1:0]  mag_reg;
  logic           neg_reg;
  logic [BW-1:0]  scratch_reg;
  logic [BW-1:0]  scratch_adj;
  logic [BW-1:0]  scratch_next;
  logic [CW-1:0]  cnt_reg;
  logic           unused_carry;

  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .din  (scratch_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .dout (scratch_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // The top digit never exceeds 4 when NDIGITS is sized correctly, so its carry-out is always 0.
  assign scratch_next = {scratch_adj[BW-2:0], mag_reg[RW-1]};
  assign unused_carry = scratch_adj[BW-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      in_reg      <= '0;
      mag_reg     <= '0;
      neg_reg     <= 1'b0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      neg_out     <= 1'b0;
      bcd_out     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done <= 1'b0;
          // A pulse in the same cycle as done is still part of the finished transaction.
          if (result_valid && !done) begin
            in_reg    <= result;
            state_reg <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          neg_reg     <= in_reg[RW-1];
          mag_reg     <= in_reg[RW-1] ? -in_reg : in_reg;
          scratch_reg <= '0;
          cnt_reg     <= '0;
          busy        <= 1'b1;
          state_reg   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          scratch_reg <= scratch_next;
          mag_reg     <= mag_reg << 1;
          cnt_reg     <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_SHIFT) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          bcd_out   <= scratch_reg;
          neg_out   <= neg_reg;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
